// File: rtl/pool_rd_ctrl_pkg.sv
// Shared accelerator package for the pooled-data read-out controller.
// Holds the FSM encoding, FIFO entry side-band and layer-size helper.
package pool_rd_ctrl_pkg;

   localparam int unsigned POOL_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_e;

   typedef struct packed {
      logic [5:0] ch;
      logic [4:0] row;
      logic [4:0] col;
      logic       last;
   } coord_t;

   function automatic logic [16:0] total_words(
      input logic [4:0] size,
      input logic [5:0] ch
   );
      logic [9:0] sq;
      sq = size * size;
      return {7'b0, sq} * {11'b0, ch};
   endfunction

endpackage

// File: rtl/pool_rd_fifo.sv
// First-word-fall-through skid FIFO for pooled words and their coordinates.
// Head entry is visible on rdata_o whenever empty_o is low.
module pool_rd_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [W-1:0]               wdata_i,
   input  logic                       pop_i,
   output logic [W-1:0]               rdata_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q;
   logic [AW-1:0] rp_q;
   logic [CW-1:0] cnt_q;
   logic          pop_ok;

   assign empty_o = (cnt_q == '0);
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rp_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wp_q] <= wdata_i;
            wp_q        <= wp_q + AW'(1);
         end
         if (pop_ok) begin
            rp_q <= rp_q + AW'(1);
         end
         unique case ({push_i, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/pool_rd_ctrl.sv
// Streams one pooled layer out of the data buffer in (ch,row,col) order.
// Reads are throttled so the skid FIFO can always absorb in-flight data.
module pool_rd_ctrl
   import pool_rd_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned FIFO_DEPTH = POOL_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [4:0]            ofmap_size_i,
   input  logic [5:0]            ifmap_ch_i,
   output logic                  sa_data_rden_o,
   output logic [ADDR_WIDTH-1:0] sa_data_rdptr_o,
   input  logic [DATA_WIDTH-1:0] sa_data_rdata_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  last_o,
   output logic [5:0]            ch_o,
   output logic [4:0]            row_o,
   output logic [4:0]            col_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CRW = $bits(coord_t);
   localparam int unsigned EW = DATA_WIDTH + CRW;
   localparam int unsigned SW = ADDR_WIDTH + 18;
   localparam logic [SW-1:0] LIMIT = SW'(1) << ADDR_WIDTH;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] hold_q, hold_d;
   logic [4:0]            size_q, size_d;
   logic [16:0]           rem_q, rem_d;
   logic [4:0]            col_q, col_d;
   logic [4:0]            row_q, row_d;
   logic [5:0]            ch_q, ch_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  infl_q;
   coord_t                icrd_q, cur_crd, head_crd;

   logic [16:0]           total;
   logic [SW-1:0]         end_addr;
   logic [CW-1:0]         fifo_cnt;
   logic [CW:0]           occ;
   logic                  rden, pop, empty;
   logic [EW-1:0]         fifo_rdata;

   assign total    = total_words(ofmap_size_i, ifmap_ch_i);
   assign end_addr = SW'(base_addr_i) + SW'(total);
   assign occ      = {1'b0, fifo_cnt} + (CW+1)'(infl_q);
   assign rden     = (state_q == S_RUN) && (occ < (CW+1)'(FIFO_DEPTH));
   assign cur_crd  = '{ch: ch_q, row: row_q, col: col_q,
                       last: (rem_q == 17'd1)};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hold_d  = hold_q;
      size_d  = size_q;
      rem_d   = rem_q;
      col_d   = col_q;
      row_d   = row_q;
      ch_d    = ch_q;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               err_d = 1'b0;
               if (total == '0) begin
                  done_d = 1'b1;
               end else if (end_addr > LIMIT) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  addr_d  = base_addr_i;
                  size_d  = ofmap_size_i;
                  rem_d   = total;
                  col_d   = '0;
                  row_d   = '0;
                  ch_d    = '0;
               end
            end
         end
         S_RUN: begin
            if (rden) begin
               hold_d = addr_q;
               addr_d = addr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - 17'd1;
               if (col_q == size_q - 5'd1) begin
                  col_d = '0;
                  if (row_q == size_q - 5'd1) begin
                     row_d = '0;
                     ch_d  = ch_q + 6'd1;
                  end else begin
                     row_d = row_q + 5'd1;
                  end
               end else begin
                  col_d = col_q + 5'd1;
               end
               if (rem_q == 17'd1) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head_crd.last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         hold_q  <= '0;
         size_q  <= '0;
         rem_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         ch_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         infl_q  <= 1'b0;
         icrd_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hold_q  <= hold_d;
         size_q  <= size_d;
         rem_q   <= rem_d;
         col_q   <= col_d;
         row_q   <= row_d;
         ch_q    <= ch_d;
         done_q  <= done_d;
         err_q   <= err_d;
         infl_q  <= rden;
         icrd_q  <= cur_crd;
      end
   end

   // Read data lands one cycle after rden; its coordinates ride along in icrd_q.
   pool_rd_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (infl_q),
      .wdata_i ({sa_data_rdata_i, icrd_q}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (empty),
      .count_o (fifo_cnt)
   );

   assign head_crd = coord_t'(fifo_rdata[CRW-1:0]);
   assign valid_o  = ~empty;
   assign pop      = valid_o & ready_i;

   assign data_o   = valid_o ? fifo_rdata[EW-1 -: DATA_WIDTH] : '0;
   assign ch_o     = valid_o ? head_crd.ch : '0;
   assign row_o    = valid_o ? head_crd.row : '0;
   assign col_o    = valid_o ? head_crd.col : '0;
   assign last_o   = valid_o & head_crd.last;

   assign sa_data_rden_o  = rden;
   assign sa_data_rdptr_o = rden ? addr_q : hold_q;
   assign busy_o          = (state_q != S_IDLE);
   assign done_o          = done_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_pool_rd_ctrl.sv
// Directed bench for pool_rd_ctrl: memory model plus per-word expectations.
// Expected data is a fixed function of address; coords derive from word index.
module tb_pool_rd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [13:0] base_addr_i = '0;
   logic [4:0]  ofmap_size_i = '0;
   logic [5:0]  ifmap_ch_i = '0;
   logic        rden;
   logic [13:0] rdptr;
   logic [7:0]  rdata = '0;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic        last_o;
   logic [5:0]  ch_o;
   logic [4:0]  row_o;
   logic [4:0]  col_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pool_rd_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .base_addr_i     (base_addr_i),
      .ofmap_size_i    (ofmap_size_i),
      .ifmap_ch_i      (ifmap_ch_i),
      .sa_data_rden_o  (rden),
      .sa_data_rdptr_o (rdptr),
      .sa_data_rdata_i (rdata),
      .data_o          (data_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .last_o          (last_o),
      .ch_o            (ch_o),
      .row_o           (row_o),
      .col_o           (col_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o)
   );

   function automatic logic [7:0] mem_f(input logic [13:0] a);
      return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      if (rden) rdata <= mem_f(rdptr);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready high; 1: ready toggles; 2: ready low 12 cycles; 3: ready high + stray start
   task automatic run_layer(input logic [13:0] base, input logic [4:0] sz,
                            input logic [5:0] nch, input int mode);
      int   total, k, reads, cyc, first_rd;
      logic fin, last_hs, prev_hold;
      logic [7:0] prev_d;
      total = sz * sz * nch;
      k = 0; reads = 0; cyc = 0; first_rd = -1;
      fin = 1'b0; last_hs = 1'b0; prev_hold = 1'b0; prev_d = '0;
      base_addr_i = base; ofmap_size_i = sz; ifmap_ch_i = nch;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      while (!fin && cyc < 600) begin
         unique case (mode)
            1:       ready_i = (cyc % 2 == 0);
            2:       ready_i = (cyc >= 12);
            default: ready_i = 1'b1;
         endcase
         if (mode == 3 && cyc == 5) begin
            start_i = 1'b1;
            base_addr_i = 14'h0000;
         end else begin
            start_i = 1'b0;
         end
         #1;
         if (last_hs) begin
            chk("done_pulse", done_o, 1);
            chk("busy_end", busy_o, 0);
            fin = 1'b1;
         end else begin
            chk("done_early", done_o, 0);
            if (cyc == 0) begin
               chk("first_rden", rden, 1);
               chk("first_ptr", rdptr, base);
               chk("err_clr", err_o, 0);
               chk("busy_run", busy_o, 1);
            end
            if (rden) begin
               chk("rdptr", rdptr, 32'(base) + reads);
               if (reads == 0) first_rd = cyc;
               reads++;
            end else if (reads > 0) begin
               chk("rdptr_hold", rdptr, 32'(base) + reads - 1);
            end
            if (valid_o && k == 0 && !prev_hold)
               chk("vld_latency", cyc - first_rd, 2);
            if (prev_hold) chk("stall_data", data_o, prev_d);
            if (mode == 2 && cyc == 12) begin
               chk("stall_reads", reads, 4);
               chk("stall_rden", rden, 0);
            end
            last_hs = 1'b0;
            if (valid_o && ready_i) begin
               chk("data", data_o, mem_f(14'(32'(base) + k)));
               chk("col", col_o, k % sz);
               chk("row", row_o, (k / sz) % sz);
               chk("ch", ch_o, k / (sz * sz));
               chk("last", last_o, k == total - 1);
               k++;
               last_hs = (k == total);
            end
            prev_hold = valid_o && !ready_i;
            prev_d = data_o;
            cyc++;
            tick();
         end
      end
      chk("timeout", fin, 1);
      chk("words", k, total);
      chk("reads", reads, total);
      ready_i = 1'b0;
      tick();
      chk("done_once", done_o, 0);
   endtask

   task automatic run_empty(input logic [13:0] base, input logic [4:0] sz,
                            input logic [5:0] nch, input logic exp_err);
      base_addr_i = base; ofmap_size_i = sz; ifmap_ch_i = nch;
      start_i = 1'b1;
      chk("e_rden0", rden, 0);
      tick();
      start_i = 1'b0;
      chk("e_done", done_o, 1);
      chk("e_err", err_o, exp_err);
      chk("e_rden", rden, 0);
      chk("e_busy", busy_o, 0);
      tick();
      chk("e_done_off", done_o, 0);
      chk("e_err_sticky", err_o, exp_err);
      chk("e_rden2", rden, 0);
      chk("e_valid", valid_o, 0);
   endtask

   initial begin
      tick();
      chk("rst_valid", valid_o, 0);
      chk("rst_rden", rden, 0);
      chk("rst_ptr", rdptr, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_last", last_o, 0);
      rst_n = 1'b1;
      tick();

      run_layer(14'h0100, 5'd2, 6'd1, 0);
      run_layer(14'h0020, 5'd3, 6'd2, 2);
      run_layer(14'h3000, 5'd4, 6'd4, 1);

      run_empty(14'h0010, 5'd0, 6'd3, 1'b0);
      run_empty(14'h0010, 5'd4, 6'd0, 1'b0);
      run_empty(14'h3FF0, 5'd5, 6'd1, 1'b1);

      run_layer(14'h3FE7, 5'd5, 6'd1, 3);

      base_addr_i = 14'h0050; ofmap_size_i = 5'd4; ifmap_ch_i = 6'd2;
      ready_i = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_rst_valid", valid_o, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", valid_o, 0);
      chk("mid_rst_rden", rden, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_data", data_o, 0);
      chk("mid_rst_ptr", rdptr, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", valid_o, 0);
      chk("post_rst_busy", busy_o, 0);

      run_layer(14'h0200, 5'd2, 6'd3, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pool_rd_ctrl.md
POOL_RD_CTRL -- requirements
Module: pool_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning pooled-data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning pooled-data buffer read-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output skid FIFO entries (power of 2, >=2).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have start_i  in  1  one-cycle request to begin a layer read-out.
REQ-006 SHALL have base_addr_i  in  ADDR_WIDTH  first buffer address of the layer.
REQ-007 SHALL have ofmap_size_i  in  5  pooled map side length, in words.
REQ-008 SHALL have ifmap_ch_i  in  6  channel count.
REQ-009 SHALL have sa_data_rden_o  out  1  pooled-data buffer read enable.
REQ-010 SHALL have sa_data_rdptr_o  out  ADDR_WIDTH  pooled-data buffer read address.
REQ-011 SHALL have sa_data_rdata_i  in  DATA_WIDTH  buffer read data, valid exactly 1 cycle after rden.
REQ-012 SHALL have data_o  out  DATA_WIDTH, valid_o  out  1, ready_i  in  1, last_o  out  1: output stream to next-layer loader.
REQ-013 SHALL have ch_o  out  6, row_o  out  5, col_o  out  5: coordinates of the word on data_o.
REQ-014 SHALL have busy_o  out  1, done_o  out  1 (one-cycle pulse), err_o  out  1 (sticky until next accepted start).

Function
REQ-015 SHALL use FSM states IDLE, RUN, DRAIN; IDLE->RUN on start_i; RUN->DRAIN when the last read is issued; DRAIN->IDLE when the last word handshakes.
REQ-016 SHALL latch base, size, ch on the accepted start_i; start_i outside IDLE SHALL be ignored.
REQ-017 SHALL treat total = size*size*ch (17-bit); if total==0, SHALL go to IDLE with done_o pulsed the next cycle and no reads.
REQ-018 SHALL set err_o and complete as REQ-017 (no reads) when base + total > 2^ADDR_WIDTH.
REQ-019 SHALL issue reads in order col fastest, then row, then ch, rdptr = base + linear index, incrementing by 1.
REQ-020 SHALL assert rden only in RUN when fifo_count + inflight < FIFO_DEPTH, inflight = rden of the previous cycle.
REQ-021 SHALL assert the first rden in the cycle after the accepted start, with rdptr = base.
REQ-022 SHALL write rdata into the FIFO at the edge ending the cycle after rden, so valid_o rises 2 cycles after the first rden.
REQ-023 SHALL present FIFO head combinationally on data_o/ch_o/row_o/col_o/last_o; valid_o = FIFO non-empty.
REQ-024 SHALL pop on valid_o & ready_i; data_o and coordinates SHALL hold while valid_o & !ready_i.
REQ-025 SHALL support simultaneous push and pop with count unchanged; FIFO SHALL never overflow nor drop a word.
REQ-026 SHALL assert last_o only with the final word (index total-1).
REQ-027 SHALL pulse done_o in the cycle after the last handshake; busy_o = state != IDLE.
REQ-028 SHALL hold sa_data_rdptr_o at its last value when rden is low.

Reset
REQ-029 SHALL, on rst_n low (any time, including mid-layer), force state IDLE, FIFO empty, inflight 0, all counters 0, and all outputs 0 asynchronously.
REQ-030 SHALL discard rdata arriving in the first cycle after reset release.

Structure
REQ-031 SHALL place the FSM state enum and default FIFO_DEPTH in the shared accelerator package.
REQ-032 SHALL implement the FIFO as sub-module pool_rd_fifo (FWFT, parameterised width/depth); FSM, counters, address generation in pool_rd_ctrl.

Verification
REQ-033 size=2, ch=1, base=0x100, ready_i=1 -> reads 0x100..0x103, 4 words, last_o on 4th, done_o one cycle later.
REQ-034 size=3, ch=2, ready_i held 0 -> exactly FIFO_DEPTH reads then rden low; on ready_i=1 all 18 words in order with coords (ch,row,col) correct.
REQ-035 ready_i toggling 1/0 every cycle, size=4, ch=4 -> 64 words, no loss/duplication, data_o stable during stalls.
REQ-036 size=0 or ch=0 -> no rden, done_o pulses once; base=0x3FF0, size=5, ch=1 -> err_o=1, no reads.
REQ-037 start_i during RUN -> ignored; rst_n low mid-RUN -> valid_o, rden_o, busy_o 0 immediately; next start reads from new base correctly.
